dg0045_ram_arbiter: RTL and testbench

DG0045_RAM_ARBITER -- requirements
Module: DG0045_RAM_arbiter

---
 rtl/dg0045_ram_arbiter.sv | 108 ++++++++++
 tb/tb_dg0045_ram_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dg0045_ram_arbiter.sv
// Two-port round-robin arbiter in front of a single-port RAM that writes on every clock.
// Non-write cycles feed ram_dout back to ram_din; a clear sweep fills the RAM after reset or clr.
module dg0045_ram_arbiter #(
  parameter logic [3:0] CLR_VAL = 4'h0,
  parameter int         DEPTH   = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       a_req,
  input  logic       a_we,
  input  logic [5:0] a_addr,
  input  logic [3:0] a_wdata,
  output logic       a_gnt,
  output logic       a_rvalid,
  output logic [3:0] a_rdata,
  input  logic       b_req,
  input  logic       b_we,
  input  logic [5:0] b_addr,
  input  logic [3:0] b_wdata,
  output logic       b_gnt,
  output logic       b_rvalid,
  output logic [3:0] b_rdata,
  output logic       init_busy,
  output logic [5:0] ram_addr,
  output logic [3:0] ram_din,
  input  logic [3:0] ram_dout
);

  localparam logic ST_CLEAR = 1'b0;
  localparam logic ST_ARB   = 1'b1;
  localparam logic [5:0] LAST_LOC = 6'(DEPTH - 1);

  logic       state;
  logic [5:0] cnt;
  logic       last_b;
  logic [5:0] addr_q;
  logic       arb_ok;

  // A clr pulse in ARB blocks grants for its own cycle.
  assign arb_ok    = (state == ST_ARB) && !clr;
  assign a_gnt     = arb_ok && a_req && (!b_req || last_b);
  assign b_gnt     = arb_ok && b_req && (!a_req || !last_b);
  assign init_busy = (state == ST_CLEAR);

  always_comb begin
    ram_addr = addr_q;
    ram_din  = ram_dout;
    if (state == ST_CLEAR) begin
      ram_addr = cnt;
      ram_din  = CLR_VAL;
    end else if (a_gnt) begin
      ram_addr = a_addr;
      if (a_we) ram_din = a_wdata;
    end else if (b_gnt) begin
      ram_addr = b_addr;
      if (b_we) ram_din = b_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_CLEAR;
      cnt   <= 6'd0;
    end else begin
      case (state)
        ST_CLEAR: begin
          if (cnt == LAST_LOC) begin
            state <= ST_ARB;
            cnt   <= 6'd0;
          end else begin
            cnt <= cnt + 6'd1;
          end
        end
        default: begin
          if (clr) state <= ST_CLEAR;
        end
      endcase
    end
  end

  // Idle cycles keep pointing at the last address so the rewrite stays local.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= 6'd0;
      last_b <= 1'b1;
    end else begin
      addr_q <= ram_addr;
      if (a_gnt)      last_b <= 1'b0;
      else if (b_gnt) last_b <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_rvalid <= 1'b0;
      a_rdata  <= 4'h0;
      b_rvalid <= 1'b0;
      b_rdata  <= 4'h0;
    end else begin
      a_rvalid <= a_gnt && !a_we;
      b_rvalid <= b_gnt && !b_we;
      if (a_gnt && !a_we) a_rdata <= ram_dout;
      if (b_gnt && !b_we) b_rdata <= ram_dout;
    end
  end

endmodule

// File: tb/tb_dg0045_ram_arbiter.sv
// Bench for dg0045_ram_arbiter with a behavioural always-writing RAM attached.
module tb_dg0045_ram_arbiter;

  localparam logic [3:0] CLR = 4'h0;

  logic       clk = 1'b0;
  logic       rst_n, clr;
  logic       a_req, a_we, b_req, b_we;
  logic [5:0] a_addr, b_addr;
  logic [3:0] a_wdata, b_wdata;
  logic       a_gnt, a_rvalid, b_gnt, b_rvalid, init_busy;
  logic [3:0] a_rdata, b_rdata;
  logic [5:0] ram_addr;
  logic [3:0] ram_din, ram_dout;

  logic [3:0] mem [64];
  logic       seeded = 1'b0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  dg0045_ram_arbiter #(.CLR_VAL(CLR), .DEPTH(64)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .init_busy(init_busy), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  // RAM has no write enable: every edge writes ram_din. Seeded with non-clear data first.
  assign ram_dout = mem[ram_addr];
  always @(posedge clk) begin
    if (!seeded) begin
      for (int i = 0; i < 64; i++) mem[i] <= 4'(i % 15 + 1);
    end else begin
      mem[ram_addr] <= ram_din;
    end
  end

  typedef struct {
    logic       a_req, a_we;
    logic [5:0] a_addr;
    logic [3:0] a_wdata;
    logic       b_req, b_we;
    logic [5:0] b_addr;
    logic [3:0] b_wdata;
    logic       ag, bg;
    logic [5:0] addr;
    logic [3:0] din;
    logic       arv;
    logic [3:0] ard;
    logic       brv;
    logic [3:0] brd;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic access(input bit side_b, input bit we, input logic [5:0] addr,
                        input logic [3:0] wd, output logic [3:0] rd);
    int n;
    @(posedge clk); #1;
    if (side_b) begin
      b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wd;
    end else begin
      a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wd;
    end
    n = 0;
    @(negedge clk);
    while (!(side_b ? b_gnt : a_gnt) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      tests++;
      fails++;
      $display("FAIL gnt_timeout: got no grant, want grant within 300 cycles");
    end
    @(posedge clk); #1;
    if (side_b) b_req = 1'b0; else a_req = 1'b0;
    rd = side_b ? b_rdata : a_rdata;
    if (!we) chk(side_b ? "b_rvalid" : "a_rvalid", {7'd0, side_b ? b_rvalid : a_rvalid}, 8'd1);
  endtask

  // Starts at posedge+1 of the first cycle to count; returns at the negedge of the first grant cycle.
  task automatic measure(input int clr_at, output int busy, output int first);
    busy = 0;
    first = 0;
    for (int c = 1; c <= 200 && first == 0; c++) begin
      clr = (c == clr_at);
      @(negedge clk);
      if (a_gnt || b_gnt) first = c;
      else begin
        if (init_busy) busy++;
        @(posedge clk); #1;
      end
    end
    clr = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, {7'd0, init_busy}, 8'd1);
    chk({tag, "_agnt"}, {7'd0, a_gnt}, 8'd0);
    chk({tag, "_bgnt"}, {7'd0, b_gnt}, 8'd0);
    chk({tag, "_arv"}, {7'd0, a_rvalid}, 8'd0);
    chk({tag, "_brv"}, {7'd0, b_rvalid}, 8'd0);
    chk({tag, "_ard"}, {4'd0, a_rdata}, 8'h0);
    chk({tag, "_brd"}, {4'd0, b_rdata}, 8'h0);
    chk({tag, "_addr"}, {2'd0, ram_addr}, 8'd0);
    chk({tag, "_din"}, {4'd0, ram_din}, {4'd0, CLR});
  endtask

  initial begin
    int busy, first;
    logic [3:0] d;

    vecs[0]  = '{0,0,6'd0,4'h0,  0,0,6'd0,4'h0,  0,0,6'd6,4'h0,  0,4'h0,0,4'h0};
    vecs[1]  = '{1,1,6'd10,4'h7, 1,0,6'd5,4'h0,  0,1,6'd5,4'hA,  0,4'h0,0,4'h0};
    vecs[2]  = '{1,1,6'd10,4'h7, 1,0,6'd5,4'h0,  1,0,6'd10,4'h7, 0,4'h0,1,4'hA};
    vecs[3]  = '{1,0,6'd10,4'h0, 1,1,6'd20,4'hC, 0,1,6'd20,4'hC, 0,4'h0,0,4'hA};
    vecs[4]  = '{1,0,6'd10,4'h0, 0,0,6'd0,4'h0,  1,0,6'd10,4'h7, 0,4'h0,0,4'hA};
    vecs[5]  = '{0,0,6'd0,4'h0,  1,0,6'd20,4'h0, 0,1,6'd20,4'hC, 1,4'h7,0,4'hA};
    vecs[6]  = '{0,0,6'd0,4'h0,  0,0,6'd0,4'h0,  0,0,6'd20,4'hC, 0,4'h7,1,4'hC};
    vecs[7]  = '{0,0,6'd0,4'h0,  0,0,6'd0,4'h0,  0,0,6'd20,4'hC, 0,4'h7,0,4'hC};
    vecs[8]  = '{1,1,6'd21,4'h9, 0,0,6'd0,4'h0,  1,0,6'd21,4'h9, 0,4'h7,0,4'hC};
    vecs[9]  = '{1,0,6'd21,4'h0, 0,0,6'd0,4'h0,  1,0,6'd21,4'h9, 0,4'h7,0,4'hC};
    vecs[10] = '{1,0,6'd10,4'h0, 1,0,6'd5,4'h0,  0,1,6'd5,4'hA,  1,4'h9,0,4'hC};
    vecs[11] = '{1,0,6'd10,4'h0, 1,0,6'd5,4'h0,  1,0,6'd10,4'h7, 0,4'h9,1,4'hA};
    vecs[12] = '{0,0,6'd0,4'h0,  0,0,6'd0,4'h0,  0,0,6'd10,4'h7, 1,4'h7,0,4'hA};

    rst_n = 1'b0; clr = 1'b0;
    a_req = 1'b1; a_we = 1'b0; a_addr = 6'd0; a_wdata = 4'h0;
    b_req = 1'b0; b_we = 1'b0; b_addr = 6'd0; b_wdata = 4'h0;
    @(posedge clk); #1 seeded = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst");

    // Release with a_req held: 64 busy cycles, first grant in cycle 65.
    @(posedge clk); #1 rst_n = 1'b1;
    measure(0, busy, first);
    chk("sweep_busy", 8'(busy), 8'd64);
    chk("sweep_first_gnt", 8'(first), 8'd65);
    for (int i = 0; i < 64; i++) begin
      access(0, 0, 6'(i), 4'h0, d);
      chk("clr_loc", {4'd0, d}, {4'd0, CLR});
    end

    // Write 5, read back, neighbours untouched, rvalid is a single-cycle pulse.
    access(0, 1, 6'd5, 4'hA, d);
    access(0, 0, 6'd5, 4'h0, d);
    chk("rd5", {4'd0, d}, 8'hA);
    @(posedge clk); #1;
    chk("arv_pulse", {7'd0, a_rvalid}, 8'd0);
    access(0, 0, 6'd4, 4'h0, d);
    chk("rd4", {4'd0, d}, {4'd0, CLR});
    access(0, 0, 6'd6, 4'h0, d);
    chk("rd6", {4'd0, d}, {4'd0, CLR});
    @(posedge clk); #1;

    for (int v = 0; v < 13; v++) begin
      @(posedge clk); #1;
      a_req = vecs[v].a_req; a_we = vecs[v].a_we; a_addr = vecs[v].a_addr; a_wdata = vecs[v].a_wdata;
      b_req = vecs[v].b_req; b_we = vecs[v].b_we; b_addr = vecs[v].b_addr; b_wdata = vecs[v].b_wdata;
      @(negedge clk);
      chk($sformatf("v%0d_agnt", v), {7'd0, a_gnt}, {7'd0, vecs[v].ag});
      chk($sformatf("v%0d_bgnt", v), {7'd0, b_gnt}, {7'd0, vecs[v].bg});
      chk($sformatf("v%0d_addr", v), {2'd0, ram_addr}, {2'd0, vecs[v].addr});
      chk($sformatf("v%0d_din", v), {4'd0, ram_din}, {4'd0, vecs[v].din});
      chk($sformatf("v%0d_arv", v), {7'd0, a_rvalid}, {7'd0, vecs[v].arv});
      chk($sformatf("v%0d_ard", v), {4'd0, a_rdata}, {4'd0, vecs[v].ard});
      chk($sformatf("v%0d_brv", v), {7'd0, b_rvalid}, {7'd0, vecs[v].brv});
      chk($sformatf("v%0d_brd", v), {4'd0, b_rdata}, {4'd0, vecs[v].brd});
    end

    // Continuous contention: last grant was A, so B first, then strict alternation.
    @(posedge clk); #1;
    a_req = 1'b1; a_we = 1'b0; a_addr = 6'd1;
    b_req = 1'b1; b_we = 1'b0; b_addr = 6'd2;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk($sformatf("rr%0d_agnt", k), {7'd0, a_gnt}, {7'd0, (k % 2 == 1)});
      chk($sformatf("rr%0d_bgnt", k), {7'd0, b_gnt}, {7'd0, (k % 2 == 0)});
      @(posedge clk); #1;
    end
    a_req = 1'b0; b_req = 1'b0;

    // Fill with 3, idle 100 cycles, read everything back through B.
    for (int i = 0; i < 64; i++) access(0, 1, 6'(i), 4'h3, d);
    repeat (100) @(posedge clk);
    for (int i = 0; i < 64; i++) begin
      access(1, 0, 6'(i), 4'h0, d);
      chk("idle_keep", {4'd0, d}, 8'h3);
    end

    // clr together with b_req: no grant that cycle; a second clr mid-sweep is ignored.
    @(posedge clk); #1;
    clr = 1'b1; b_req = 1'b1; b_we = 1'b0; b_addr = 6'd7;
    @(negedge clk);
    chk("clr_bgnt", {7'd0, b_gnt}, 8'd0);
    chk("clr_agnt", {7'd0, a_gnt}, 8'd0);
    @(posedge clk); #1;
    measure(10, busy, first);
    chk("clr_sweep_busy", 8'(busy), 8'd64);
    chk("clr_first_gnt", 8'(first), 8'd65);
    chk("clr_first_is_b", {7'd0, b_gnt}, 8'd1);
    @(posedge clk); #1 b_req = 1'b0;
    for (int i = 0; i < 64; i++) begin
      access(0, 0, 6'(i), 4'h0, d);
      chk("clr2_loc", {4'd0, d}, {4'd0, CLR});
    end

    // Load both rdata registers, then reset in the middle of a sweep.
    access(0, 1, 6'd50, 4'h7, d);
    access(0, 0, 6'd50, 4'h0, d);
    access(1, 0, 6'd50, 4'h0, d);
    chk("pre_rst_brd", {4'd0, d}, 8'h7);
    @(posedge clk); #1 clr = 1'b1;
    @(posedge clk); #1 clr = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    a_req = 1'b1; a_we = 1'b0; a_addr = 6'd0;
    @(negedge clk);
    chk("mid_sweep_addr", {2'd0, ram_addr}, 8'd30);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    measure(0, busy, first);
    chk("rst_sweep_busy", 8'(busy), 8'd64);
    chk("rst_first_gnt", 8'(first), 8'd65);
    @(posedge clk); #1 a_req = 1'b0;
    access(0, 0, 6'd50, 4'h0, d);
    chk("rst_rd50", {4'd0, d}, {4'd0, CLR});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
